reg_scoreboard: RTL
===================

// Module: reg_scoreboard
// PURPOSE
//  In-order issue controller between the data-fetch and execute stages of the core pipeline.
//  Tracks outstanding register writers with per-register counters.
//  - Issue: gates each decoded micro-op on RAW hazards, writer-count saturation and an in-flight limit.
//  - Writeback: clears counts as results write back.
//  - Branch flush: sequences a drain of the pipeline before fetch is redirected.
//  Replaces the single-bit occupancy table, which cannot handle multi-target uops (e.g. dest + RSP).
// PARAMETERS
//  NREGS         17  architectural registers tracked (GPR index 0..NREGS-1)
//  CNT_W         2   width of each per-register writer counter; max pending writers = 2**CNT_W-1
//  MAX_INFLIGHT  4   max uops issued but not yet written back
// PORTS
//  clk           in   1      core clock
//  reset         in   1      asynchronous, active-high reset
//  iss_valid     in   1      DF stage presents a uop
//  iss_src_mask  in   NREGS  one-hot-per-bit set of registers the uop reads
//  iss_dst_mask  in   NREGS  set of registers the uop writes (0..2 bits set)
//  iss_ready     out  1      uop may issue this cycle; issue fires = iss_valid & iss_ready
//  wb_valid      in   1      one uop retires this cycle (exactly one pulse per issued uop, including squashed uops)
//  wb_dst_mask   in   NREGS  registers released by the retiring uop (must equal its issue dst mask)
//  flush_req     in   1      branch redirect request (level or pulse)
//  flush_done    out  1      one-cycle pulse: pipeline drained, fetch may restart
//  busy_mask     out  NREGS  bit i = counter[i] != 0
//  inflight      out  $clog2(MAX_INFLIGHT+1)  issued-not-retired uop count
//  err_underflow out  1      sticky: wb released a register or uop that was not pending
// BEHAVIOUR
//  Reset (async, any state): all counters 0, inflight 0, state RUN; iss_ready 0 while reset is high.
//   All other outputs 0 during reset.
//  States: RUN, DRAIN, DONE.
//   RUN -> DRAIN when flush_req=1.
//   DRAIN -> DONE when inflight==0, evaluated after this cycle's wb.
//   DONE -> RUN unconditionally; flush_done=1 only in DONE.
//  flush_req seen in DRAIN/DONE is ignored; no re-arm.
//   Exception: flush_req high again in the first RUN cycle after DONE starts a new drain.
//  iss_ready=1 iff all of the following hold:
//   - state==RUN and flush_req==0;
//   - no src bit hits a busy counter;
//   - no dst counter == 2**CNT_W-1;
//   - inflight < MAX_INFLIGHT, or wb_valid this cycle.
//  WAW is permitted; writeback is in order. iss_ready is combinational, with no dependence on iss_valid.
//  Per-cycle counter update, reg i: +1 if fire & dst[i]; -1 if wb_valid & wb_dst[i].
//   Both in the same cycle: net unchanged.
//   Decrement at 0: hold 0, set err_underflow.
//  inflight: +1 on fire, -1 on wb_valid, both = unchanged. Decrement at 0: hold, set err_underflow.
//  Issue latency: 0 cycles (combinational ready). Counter/busy_mask update visible next cycle.
//  err_underflow clears only on reset.
// CONFIGURATION
//  SCOREBOARD_BYPASS_EN defined:
//   - Src hazard uses the post-writeback count: a reg with count 1 and wb_dst set this cycle is free.
//   - Back-to-back dependent issue is therefore possible in the wb cycle.
//  Undefined: src hazard uses registered counts only; one bubble after each dependent writeback.
//  busy_mask always reflects registered counts in both modes.
// STRUCTURE
//  Package core_sched_pkg: NREGS, reg_mask_t (logic[NREGS-1:0]), sb_state_t enum {RUN,DRAIN,DONE}.
//  Sub-module sb_counter: CNT_W up/down saturating counter with inc, dec, cnt, zero, full, underflow.
//   Instantiated NREGS times via generate.
//  Top level: FSM, inflight counter, hazard reduction logic, error OR.
// TESTING
//  1. Reset then issue: dst={RAX}, src=0.
//     -> fire; busy_mask[RAX]=1 next cycle, inflight=1.
//     Then src={RAX} -> iss_ready=0 until wb of RAX.
//  2. Dependent uop presented in the same cycle as wb_dst={RAX}.
//     -> BYPASS_EN: ready=1 that cycle; no bypass: ready=0, ready=1 next cycle.
//  3. Three writers to RBX issued back to back (CNT_W=2).
//     -> counter 3, 4th writer of RBX stalls.
//     One wb RBX plus same-cycle issue of RBX -> counter stays 3.
//  4. Fill 4 in-flight uops -> ready=0.
//     wb_valid in the same cycle as the 5th presented uop -> fires, inflight stays 4.
//  5. 2 uops in flight, pulse flush_req -> ready=0 from that cycle.
//     Two wb pulses -> flush_done pulse exactly one cycle after the last wb; RUN after.
//  6. Assert reset mid-DRAIN with counters nonzero -> all counters/inflight 0 immediately, state RUN.
//     wb with no pending uop -> err_underflow=1 and sticky.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared types and sizing for the register scoreboard (issue/writeback hazard tracking).
// Optional build macro used by the scoreboard: SCOREBOARD_BYPASS_EN.
package core_sched_pkg;

  localparam int NREGS        = 17;
  localparam int CNT_W        = 2;
  localparam int MAX_INFLIGHT = 4;
  localparam int INFL_W       = $clog2(MAX_INFLIGHT + 1);

  typedef logic [NREGS-1:0] reg_mask_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } sb_state_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue, writeback and flush signals between the fetch/execute pipeline and the scoreboard.
interface reg_scoreboard_if;
  import core_sched_pkg::*;

  logic                iss_valid;
  reg_mask_t           iss_src_mask;
  reg_mask_t           iss_dst_mask;
  logic                iss_ready;
  logic                wb_valid;
  reg_mask_t           wb_dst_mask;
  logic                flush_req;
  logic                flush_done;
  reg_mask_t           busy_mask;
  logic [INFL_W-1:0]   inflight;
  logic                err_underflow;

  modport master (
    output iss_valid, iss_src_mask, iss_dst_mask, wb_valid, wb_dst_mask, flush_req,
    input  iss_ready, flush_done, busy_mask, inflight, err_underflow
  );

  modport slave (
    input  iss_valid, iss_src_mask, iss_dst_mask, wb_valid, wb_dst_mask, flush_req,
    output iss_ready, flush_done, busy_mask, inflight, err_underflow
  );

endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// Per-register pending-writer counter: saturating up/down, simultaneous inc+dec cancel out.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero,
  output logic             o_full,
  output logic             o_underflow
);

  logic [CNT_W-1:0] r_cnt;

  assign o_cnt       = r_cnt;
  assign o_zero      = (r_cnt == {CNT_W{1'b0}});
  assign o_full      = (r_cnt == {CNT_W{1'b1}});
  assign o_underflow = i_dec & ~i_inc & o_zero;

  // Count update; a release at zero holds and is reported through o_underflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_inc && !i_dec && !o_full) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (i_dec && !i_inc && !o_zero) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// In-order issue scoreboard: RAW/writer-count/in-flight gating plus branch-flush drain FSM.
// Build option SCOREBOARD_BYPASS_EN lets a source read a register whose last writer retires this cycle.
module reg_scoreboard
  import core_sched_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  reg_scoreboard_if.slave sb_if
);

  sb_state_t         r_state;
  logic              r_flush_done;
  logic              r_err;
  logic [INFL_W-1:0] r_inflight;
  logic [INFL_W-1:0] w_infl_next;
  logic              w_infl_uf;

  logic [CNT_W-1:0]  w_cnt [NREGS];
  reg_mask_t         w_zero;
  reg_mask_t         w_full;
  reg_mask_t         w_uf;
  reg_mask_t         w_busy;
  reg_mask_t         w_src_busy;

  logic              w_raw;
  logic              w_full_hit;
  logic              w_room;
  logic              w_ready;
  logic              w_fire;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk         (clk),
      .reset       (reset),
      .i_inc       (w_fire & sb_if.iss_dst_mask[gi]),
      .i_dec       (sb_if.wb_valid & sb_if.wb_dst_mask[gi]),
      .o_cnt       (w_cnt[gi]),
      .o_zero      (w_zero[gi]),
      .o_full      (w_full[gi]),
      .o_underflow (w_uf[gi])
    );

    assign w_busy[gi] = (w_cnt[gi] != {CNT_W{1'b0}});

`ifdef SCOREBOARD_BYPASS_EN
    // A sole pending writer retiring this cycle no longer blocks its readers.
    assign w_src_busy[gi] = ~w_zero[gi] &
                            ~((w_cnt[gi] == CNT_W'(1)) & sb_if.wb_valid & sb_if.wb_dst_mask[gi]);
`else
    assign w_src_busy[gi] = ~w_zero[gi];
`endif
  end

  assign w_raw      = |(sb_if.iss_src_mask & w_src_busy);
  assign w_full_hit = |(sb_if.iss_dst_mask & w_full);
  assign w_room     = (r_inflight < INFL_W'(MAX_INFLIGHT)) | sb_if.wb_valid;
  assign w_ready    = ~reset & (r_state == RUN) & ~sb_if.flush_req &
                      ~w_raw & ~w_full_hit & w_room;
  assign w_fire     = sb_if.iss_valid & w_ready;

  // Next in-flight count; a retire with nothing outstanding holds and flags underflow.
  always_comb begin
    w_infl_next = r_inflight;
    w_infl_uf   = 1'b0;
    if (w_fire && !sb_if.wb_valid) begin
      w_infl_next = r_inflight + INFL_W'(1);
    end else if (!w_fire && sb_if.wb_valid) begin
      if (r_inflight == {INFL_W{1'b0}}) begin
        w_infl_uf = 1'b1;
      end else begin
        w_infl_next = r_inflight - INFL_W'(1);
      end
    end else begin
      w_infl_next = r_inflight;
    end
  end

  // In-flight uop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight <= {INFL_W{1'b0}};
    end else begin
      r_inflight <= w_infl_next;
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | (|w_uf) | w_infl_uf;
    end
  end

  // Flush sequencer; flush_done is registered so it is high exactly while in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= RUN;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      case (r_state)
        RUN: begin
          if (sb_if.flush_req) begin
            r_state <= DRAIN;
          end else begin
            r_state <= RUN;
          end
        end
        DRAIN: begin
          if (w_infl_next == {INFL_W{1'b0}}) begin
            r_state      <= DONE;
            r_flush_done <= 1'b1;
          end else begin
            r_state <= DRAIN;
          end
        end
        DONE: begin
          r_state <= RUN;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign sb_if.iss_ready     = w_ready;
  assign sb_if.flush_done    = r_flush_done;
  assign sb_if.busy_mask     = w_busy;
  assign sb_if.inflight      = r_inflight;
  assign sb_if.err_underflow = r_err;

endmodule
